capture_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit asynchronously-reset capture register (D flip-flop bank, reset to 0) between N requesters. Each grant holds while the owner keeps its request asserted. The owner's data is captured every granted cycle. Sits in front of the shared capture/convert register and sequences which source drives it. An optional hold timeout enforces fairness.

---
 rtl/capture_reg_arbiter.sv | 152 +++++++++++++++
 tb/tb_capture_reg_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter sequencing N requesters onto one shared W-bit capture register.
// Optional hold timeout compiled in with `define CAPTURE_REG_ARBITER_TIMEOUT_EN.
module capture_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic [$clog2(N)-1:0] owner
);

  localparam int unsigned OW = $clog2(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("capture_reg_arbiter: requires N >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [W-1:0]    q_q, q_d;
  logic            qv_q, qv_d;

  logic [OW-1:0]   pick;
  logic [OW-1:0]   nxt_ptr;
  logic [W-1:0]    sel_data;

`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]   hold_q, hold_d;
`endif

  // Modular priority scan: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    logic [OW-1:0] hi_pick;
    logic [OW-1:0] lo_pick;
    logic          hi_found;
    hi_pick  = '0;
    lo_pick  = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_pick = OW'(j);
        if (OW'(j) >= ptr_q) begin
          hi_pick  = OW'(j);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  // Owner's data lane.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (OW'(i) == owner_q) sel_data = wdata[i*W +: W];
    end
  end

  assign nxt_ptr = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    q_d     = q_q;
    qv_d    = 1'b0;
`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          state_d     = HOLD;
`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      HOLD: begin
        if (req[owner_q]) begin
          q_d  = sel_data;
          qv_d = 1'b1;
`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
          hold_d = hold_q + HW'(1);
          if (hold_q == HW'(MAX_HOLD - 1)) begin
            gnt_d   = '0;
            ptr_d   = nxt_ptr;
            state_d = IDLE;
          end
`endif
        end else begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Scoreboard bench for capture_reg_arbiter: directed stimulus, captured data checked by a monitor.
// Timeout-dependent scenarios follow `CAPTURE_REG_ARBITER_TIMEOUT_EN.
module tb_capture_reg_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned W        = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [1:0]     owner;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  capture_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},     32'(gnt), 32'h0);
    check({tag, "_q"},       32'(q), 32'h0);
    check({tag, "_q_valid"}, 32'(q_valid), 32'h0);
    check({tag, "_owner"},   32'(owner), 32'h0);
  endtask

  // Monitor: every q_valid cycle must match the next expected capture.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && q_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_capture", 32'(q_valid), 32'h0);
        end else begin
          check("capture_data", 32'(q), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    // Reset with random activity on the inputs.
    rstn  = 1'b0;
    req   = N'($urandom);
    wdata = {$urandom, $urandom} ;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle_outputs("reset");
      req   = N'($urandom);
      wdata = (N*W)'({$urandom, $urandom});
    end
    req = '0;
    step();
    rstn = 1'b1;

    // First grant after reset goes to the lowest set bit.
    req = 4'b0110;
    step();
    check("first_grant_gnt", 32'(gnt), 32'h2);
    check("first_grant_owner", 32'(owner), 32'h1);
    req = '0;
    step();
    check("first_release_gnt", 32'(gnt), 32'h0);
    check("first_release_qv", 32'(q_valid), 32'h0);

    // Single requester: two captures then release (ptr=2, so scan wraps to 0).
    req = 4'b0001;
    set_lane(0, 8'h00);
    step();
    check("single_gnt_e1", 32'(gnt), 32'h1);
    check("single_owner_e1", 32'(owner), 32'h0);
    check("single_qv_e1", 32'(q_valid), 32'h0);
    set_lane(0, 8'h11);
    exp_q.push_back(8'h11);
    step();
    check("single_q_e2", 32'(q), 32'h11);
    set_lane(0, 8'h22);
    exp_q.push_back(8'h22);
    step();
    check("single_q_e3", 32'(q), 32'h22);
    check("single_gnt_e3", 32'(gnt), 32'h1);
    req = '0;
    set_lane(0, 8'h33);
    step();
    check("single_gnt_e4", 32'(gnt), 32'h0);
    check("single_qv_e4", 32'(q_valid), 32'h0);
    check("single_q_e4", 32'(q), 32'h22);

    // Reset mid-grant (ptr=1, so requester 2 wins).
    req = 4'b0100;
    step();
    check("midrst_gnt", 32'(gnt), 32'h4);
    check("midrst_owner", 32'(owner), 32'h2);
    set_lane(2, 8'hA1);
    exp_q.push_back(8'hA1);
    step();
    check("midrst_q", 32'(q), 32'hA1);
    #2 rstn = 1'b0;
    #1 check_idle_outputs("midrst");
    step();
    rstn = 1'b1;
    step();
    check("postrst_gnt", 32'(gnt), 32'h4);
    check("postrst_owner", 32'(owner), 32'h2);
    #2 rstn = 1'b0;
    req = '0;
    step();
    rstn = 1'b1;

`ifdef CAPTURE_REG_ARBITER_TIMEOUT_EN
    // All requesting: each grant lasts MAX_HOLD captures plus one idle cycle.
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int g = 0; g < 5; g++)
      for (int c = 0; c < int'(MAX_HOLD); c++)
        exp_q.push_back(8'(8'h11 * ((g % 4) + 1)));
    req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k % 5 < 4) check("rr_gnt", 32'(gnt), 32'(1 << ((k / 5) % 4)));
      else           check("rr_idle_gnt", 32'(gnt), 32'h0);
    end
    req = '0;
    step();
`endif

    // Wrap-around: owner 3 releases, pointer must return to 0.
    req = 4'b1000;
    step();
    check("wrap_gnt3", 32'(gnt), 32'h8);
    set_lane(3, 8'h5A);
    exp_q.push_back(8'h5A);
    step();
    check("wrap_q", 32'(q), 32'h5A);
    req = 4'b0001;
    step();
    check("wrap_release_gnt", 32'(gnt), 32'h0);
    req = 4'b1001;
    step();
    check("wrap_next_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    check("wrap_release2_gnt", 32'(gnt), 32'h0);

`ifndef CAPTURE_REG_ARBITER_TIMEOUT_EN
    // No timeout: owner 0 keeps the grant for as long as it requests.
    #2 rstn = 1'b0;
    step();
    rstn = 1'b1;
    req = 4'b0011;
    for (int k = 1; k <= 20; k++) begin
      set_lane(0, 8'(k * 7));
      set_lane(1, 8'hEE);
      if (k >= 2) exp_q.push_back(8'(k * 7));
      step();
      check("nto_gnt", 32'(gnt), 32'h1);
      check("nto_owner", 32'(owner), 32'h0);
    end
    req = '0;
    step();
    check("nto_release_gnt", 32'(gnt), 32'h0);
`endif

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
